// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with write-back bypass and load-use hazard bubble.
// Defining ID_EX_PERF_EN builds a stall-cycle counter on perf_stall_cnt; otherwise it is tied to 0.
module id_ex_stage #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int CTRL_W       = 8,
  parameter int MEM_READ_BIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [15:0]       id_imm16,
  input  logic [31:0]       id_pc_plus4,
  input  logic [DATA_W-1:0] reg_1_content,
  input  logic [DATA_W-1:0] reg_2_content,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [31:0]       ex_pc_plus4,
  output logic [31:0]       perf_stall_cnt
);

  logic [DATA_W-1:0] rs_operand;
  logic [DATA_W-1:0] rt_operand;
  logic [DATA_W-1:0] imm_ext;
  logic              rs_match;
  logic              rt_match;
  logic              hazard;
  logic              bubble;

  // $zero always reads 0; a same-cycle write-back beats the stale register-file read.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              wb_we,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_value
  );
    logic [DATA_W-1:0] result;
    if (addr == '0)
      result = '0;
    else if (wb_we && (wb_addr == addr))
      result = wb_value;
    else
      result = rf_data;
    return result;
  endfunction

  always_comb begin
    rs_operand = select_operand(id_rs, reg_1_content, wb_reg_write, wb_write_address, wb_data);
    rt_operand = select_operand(id_rt, reg_2_content, wb_reg_write, wb_write_address, wb_data);
    imm_ext    = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
  end

  // A load in EX whose target feeds the ID instruction needs one bubble.
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    hazard   = ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rt != '0) && id_valid &&
               (rs_match || rt_match);
    bubble   = flush || hazard;
  end

  assign stall = hazard && !flush;

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_pc_plus4 <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_rs_data  <= rs_operand;
      ex_rt_data  <= rt_operand;
      ex_imm      <= imm_ext;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_pc_plus4 <= id_pc_plus4;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against a behavioural EX-slot model.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [7:0]  id_ctrl;
  logic        id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [31:0] id_pc_plus4;
  logic [31:0] reg_1_content, reg_2_content;
  logic        wb_reg_write;
  logic [4:0]  wb_write_address;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_pc_plus4;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
  } ex_slot_t;

  ex_slot_t    m;
  logic [31:0] m_perf;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm16(id_imm16), .id_pc_plus4(id_pc_plus4),
    .reg_1_content(reg_1_content), .reg_2_content(reg_2_content),
    .wb_reg_write(wb_reg_write), .wb_write_address(wb_write_address), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_pc_plus4(ex_pc_plus4),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (wb_reg_write && wb_write_address == a) return wb_data;
    return rf;
  endfunction

  function automatic logic model_stall();
    logic depends;
    depends = (m.rt == id_rs) || (id_uses_rt && m.rt == id_rt);
    return m.valid && m.ctrl[3] && m.rt != 0 && id_valid && depends && !flush;
  endfunction

  // Compare every output against the model, then advance the model across one clock edge.
  task automatic step();
    ex_slot_t    nxt;
    logic [31:0] nperf;
    logic        bubble;
    @(negedge clock);
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_ctrl", ex_ctrl, m.ctrl);
    chk("ex_rs_data", ex_rs_data, m.rs_data);
    chk("ex_rt_data", ex_rt_data, m.rt_data);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs", ex_rs, m.rs);
    chk("ex_rt", ex_rt, m.rt);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_pc_plus4", ex_pc_plus4, m.pc);
    chk("stall", stall, model_stall());
    chk("perf_stall_cnt", perf_stall_cnt, m_perf);
    // A hazard (with or without flush) or a flush means an empty slot.
    bubble = flush || (model_stall() || (m.valid && m.ctrl[3] && m.rt != 0 && id_valid &&
             ((m.rt == id_rs) || (id_uses_rt && m.rt == id_rt))));
    nxt = '{default: '0};
    if (!reset && !bubble) begin
      nxt.valid   = id_valid;
      nxt.ctrl    = id_valid ? id_ctrl : 8'd0;
      nxt.rs_data = operand(id_rs, reg_1_content);
      nxt.rt_data = operand(id_rt, reg_2_content);
      nxt.imm     = 32'($signed(id_imm16));
      nxt.rs      = id_rs;
      nxt.rt      = id_rt;
      nxt.rd      = id_rd;
      nxt.pc      = id_pc_plus4;
    end
`ifdef ID_EX_PERF_EN
    nperf = reset ? 32'd0 : m_perf + (model_stall() ? 32'd1 : 32'd0);
`else
    nperf = 32'd0;
`endif
    @(posedge clock);
    #1;
    m      = nxt;
    m_perf = nperf;
  endtask

  task automatic drive_id(input logic v, input logic [7:0] c, input logic ur,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [15:0] imm, input logic [31:0] r1, input logic [31:0] r2);
    id_valid = v; id_ctrl = c; id_uses_rt = ur; id_rs = rs; id_rt = rt; id_rd = rd;
    id_imm16 = imm; id_pc_plus4 = 32'h0040_0000 + 32'($urandom_range(0, 255) * 4);
    reg_1_content = r1; reg_2_content = r2;
  endtask

  initial begin
    m = '{default: '0};
    m_perf = 32'd0;
    reset = 1'b1; flush = 1'b0;
    wb_reg_write = 1'b0; wb_write_address = 5'd0; wb_data = 32'd0;
    drive_id(1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0, 32'd0, 32'd0);
    #1;
    step();
    step();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_rs_data", ex_rs_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    reset = 1'b0;

    drive_id(1'b1, 8'h01, 1'b1, 5'd5, 5'd6, 5'd3, 16'h8000, 32'h11, 32'h22);
    step();
    chk("t2_rs_data", ex_rs_data, 32'h11);
    chk("t2_rt_data", ex_rt_data, 32'h22);
    chk("t2_imm", ex_imm, 32'hFFFF_8000);
    chk("t2_valid", ex_valid, 1);

    drive_id(1'b1, 8'h01, 1'b0, 5'd7, 5'd0, 5'd3, 16'h0004, 32'hAA, 32'h0);
    wb_reg_write = 1'b1; wb_write_address = 5'd7; wb_data = 32'h55;
    step();
    chk("t3_bypass", ex_rs_data, 32'h55);
    id_rs = 5'd0; wb_write_address = 5'd0;
    step();
    chk("t3_zero_reg", ex_rs_data, 32'h0);
    wb_reg_write = 1'b0;

    drive_id(1'b1, 8'h08, 1'b0, 5'd1, 5'd9, 5'd9, 16'd0, 32'h1, 32'h2);
    step();
    drive_id(1'b1, 8'h01, 1'b0, 5'd9, 5'd2, 5'd4, 16'd1, 32'h99, 32'h2);
    #2;
    chk("t4_stall", stall, 1);
    step();
    chk("t4_bubble_valid", ex_valid, 0);
    chk("t4_bubble_ctrl", ex_ctrl, 0);
    #2;
    chk("t4_stall_released", stall, 0);
    step();
    chk("t4_dep_valid", ex_valid, 1);
    chk("t4_dep_rs", ex_rs, 9);
`ifdef ID_EX_PERF_EN
    chk("t4_perf", perf_stall_cnt, 1);
`endif

    drive_id(1'b1, 8'h08, 1'b0, 5'd1, 5'd9, 5'd9, 16'd0, 32'h1, 32'h2);
    step();
    drive_id(1'b1, 8'h01, 1'b0, 5'd9, 5'd2, 5'd4, 16'd1, 32'h99, 32'h2);
    flush = 1'b1;
    #2;
    chk("t5_stall", stall, 0);
    step();
    chk("t5_valid", ex_valid, 0);
    chk("t5_ctrl", ex_ctrl, 0);
    flush = 1'b0;

    drive_id(1'b1, 8'h08, 1'b1, 5'd1, 5'd0, 5'd0, 16'd0, 32'h1, 32'h2);
    step();
    drive_id(1'b1, 8'h01, 1'b1, 5'd0, 5'd0, 5'd4, 16'd1, 32'h99, 32'h2);
    #2;
    chk("t6_stall", stall, 0);
    step();
    chk("t6_valid", ex_valid, 1);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!model_stall() || reset) begin
        drive_id($urandom_range(0, 5) != 0, 8'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                 16'($urandom), $urandom, $urandom);
      end else begin
        reg_1_content = $urandom;
        reg_2_content = $urandom;
      end
      wb_reg_write     = 1'($urandom);
      wb_write_address = 5'($urandom_range(0, 3));
      wb_data          = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
